// File: rtl/parity_frame_checker.sv
// parity_frame_checker
// Bit-serial frame receiver: deserialises DATA_BITS data bits (LSB first)
// followed by one parity bit, checks the running XOR against the expected
// parity sense and presents the word on a valid/ready output. A saturating
// counter tracks parity failures.
module parity_frame_checker #(
    parameter int DATA_BITS  = 8,
    parameter int ODD_PARITY = 0,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic                 in_start,
    input  logic                 in_bit,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_parity_ok,
    input  logic                 err_clear,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int CNT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_DATA_IDX = CNT_W'(DATA_BITS - 1);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};
    localparam logic ODD_SENSE = 1'(ODD_PARITY);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // True when the accumulated data parity combined with the received
    // parity bit matches the expected sense.
    function automatic logic parity_match(input logic acc, input logic pbit);
        return ((acc ^ pbit) == ODD_SENSE);
    endfunction

    state_t                 state_r;
    logic [CNT_W-1:0]       cnt_r;
    logic                   acc_r;
    logic [DATA_BITS-1:0]   word_r;
    logic [DATA_BITS-1:0]   word_next_s;
    logic [DATA_BITS-1:0]   out_data_r;
    logic                   out_parity_ok_r;
    logic                   out_valid_r;
    logic [ERR_CNT_W-1:0]   err_count_r;
    logic                   in_ready_s;
    logic                   accept_s;
    logic                   restart_s;
    logic                   mismatch_s;

    assign in_ready_s    = (state_r != HOLD);
    assign accept_s      = in_valid && in_ready_s;
    // in_start on any accepted bit outside HOLD opens a new frame
    assign restart_s     = accept_s && in_start;
    assign mismatch_s    = accept_s && !in_start && (state_r == PARITY) &&
                           !parity_match(acc_r, in_bit);

    assign in_ready      = in_ready_s;
    assign out_valid     = out_valid_r;
    assign out_data      = out_data_r;
    assign out_parity_ok = out_parity_ok_r;
    assign err_count     = err_count_r;

    // Insert the incoming bit at the position given by the bit counter.
    always_comb begin
        word_next_s = word_r;
        for (int i = 0; i < DATA_BITS; i++) begin
            if (cnt_r == CNT_W'(i)) begin
                word_next_s[i] = in_bit;
            end else begin
                word_next_s[i] = word_r[i];
            end
        end
    end

    // Frame FSM: collects data bits, evaluates parity and holds the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= IDLE;
            cnt_r           <= {CNT_W{1'b0}};
            acc_r           <= 1'b0;
            word_r          <= {DATA_BITS{1'b0}};
            out_data_r      <= {DATA_BITS{1'b0}};
            out_parity_ok_r <= 1'b0;
            out_valid_r     <= 1'b0;
        end else if (restart_s) begin
            // New frame (or abort of the current one): bit becomes data bit 0
            state_r <= DATA;
            cnt_r   <= CNT_W'(1);
            acc_r   <= in_bit;
            word_r  <= {{(DATA_BITS - 1){1'b0}}, in_bit};
        end else begin
            case (state_r)
                IDLE: begin
                    // accepted bits without in_start are dropped here
                    state_r <= IDLE;
                end
                DATA: begin
                    if (accept_s) begin
                        word_r <= word_next_s;
                        acc_r  <= acc_r ^ in_bit;
                        cnt_r  <= cnt_r + CNT_W'(1);
                        if (cnt_r == LAST_DATA_IDX) begin
                            state_r <= PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (accept_s) begin
                        out_data_r      <= word_r;
                        out_parity_ok_r <= parity_match(acc_r, in_bit);
                        out_valid_r     <= 1'b1;
                        state_r         <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    // Saturating parity-failure counter; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_r <= {ERR_CNT_W{1'b0}};
        end else if (err_clear) begin
            err_count_r <= {ERR_CNT_W{1'b0}};
        end else if (mismatch_s && (err_count_r != ERR_MAX)) begin
            err_count_r <= err_count_r + ERR_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_parity_frame_checker.sv
// Directed bench for parity_frame_checker. Three instances share stimulus:
// even parity/8-bit counter, odd parity, and even parity with a 2-bit counter.
module tb_parity_frame_checker;

    logic clk;
    logic rst_n;
    logic in_valid;
    logic in_start;
    logic in_bit;
    logic out_ready;
    logic err_clear;

    logic       e_in_ready, e_out_valid, e_ok;
    logic [7:0] e_data;
    logic [7:0] e_err;
    logic       o_in_ready, o_out_valid, o_ok;
    logic [7:0] o_data;
    logic [7:0] o_err;
    logic       s_in_ready, s_out_valid, s_ok;
    logic [7:0] s_data;
    logic [1:0] s_err;

    int checks = 0;
    int errors = 0;

    parity_frame_checker #(.DATA_BITS(8), .ODD_PARITY(0), .ERR_CNT_W(8)) dut_even (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_start(in_start),
        .in_bit(in_bit), .in_ready(e_in_ready), .out_valid(e_out_valid),
        .out_ready(out_ready), .out_data(e_data), .out_parity_ok(e_ok),
        .err_clear(err_clear), .err_count(e_err)
    );

    parity_frame_checker #(.DATA_BITS(8), .ODD_PARITY(1), .ERR_CNT_W(8)) dut_odd (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_start(in_start),
        .in_bit(in_bit), .in_ready(o_in_ready), .out_valid(o_out_valid),
        .out_ready(out_ready), .out_data(o_data), .out_parity_ok(o_ok),
        .err_clear(err_clear), .err_count(o_err)
    );

    parity_frame_checker #(.DATA_BITS(8), .ODD_PARITY(0), .ERR_CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_start(in_start),
        .in_bit(in_bit), .in_ready(s_in_ready), .out_valid(s_out_valid),
        .out_ready(out_ready), .out_data(s_data), .out_parity_ok(s_ok),
        .err_clear(err_clear), .err_count(s_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One accepted-bit attempt; returns #1 after the edge.
    task automatic send_bit(input logic s, input logic b);
        in_valid = 1'b1;
        in_start = s;
        in_bit   = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_start = 1'b0;
        in_bit   = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    // Eight data bits LSB first with optional gaps, then the parity bit.
    task automatic send_frame(input logic [7:0] d, input logic p, input int gaps);
        for (int i = 0; i < 8; i++) begin
            send_bit(i == 0, d[i]);
            repeat (gaps) idle_cycle();
        end
        send_bit(1'b0, p);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_start = 1'b0; in_bit = 1'b0;
        out_ready = 1'b1; err_clear = 1'b0;
        #12;
        // reset state
        chk("rst_in_ready", 32'(e_in_ready), 32'd1);
        chk("rst_out_valid", 32'(e_out_valid), 32'd0);
        chk("rst_out_data", 32'(e_data), 32'h0);
        chk("rst_ok", 32'(e_ok), 32'd0);
        chk("rst_err", 32'(e_err), 32'd0);
        rst_n = 1'b1;
        idle_cycle();

        // good frame 0xA5, parity 0
        send_frame(8'hA5, 1'b0, 0);
        chk("good_valid", 32'(e_out_valid), 32'd1);
        chk("good_in_ready", 32'(e_in_ready), 32'd0);
        chk("good_data", 32'(e_data), 32'hA5);
        chk("good_ok", 32'(e_ok), 32'd1);
        chk("good_err", 32'(e_err), 32'd0);
        chk("good_odd_ok", 32'(o_ok), 32'd0);
        chk("good_odd_err", 32'(o_err), 32'd1);
        idle_cycle();
        chk("good_valid_drop", 32'(e_out_valid), 32'd0);
        chk("good_ready_back", 32'(e_in_ready), 32'd1);

        // bad frame 0x3C with gaps, parity 1
        send_frame(8'h3C, 1'b1, 1);
        chk("bad_valid", 32'(e_out_valid), 32'd1);
        chk("bad_data", 32'(e_data), 32'h3C);
        chk("bad_ok", 32'(e_ok), 32'd0);
        chk("bad_err", 32'(e_err), 32'd1);
        chk("bad_odd_ok", 32'(o_ok), 32'd1);
        chk("bad_odd_err", 32'(o_err), 32'd1);
        chk("bad_sat_err", 32'(s_err), 32'd1);
        idle_cycle();

        // backpressure: 0x5A parity 0 held with out_ready low
        out_ready = 1'b0;
        send_frame(8'h5A, 1'b0, 0);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_start = 1'b1; in_bit = 1'b1;
            @(posedge clk);
            #1;
            chk("bp_valid", 32'(e_out_valid), 32'd1);
            chk("bp_in_ready", 32'(e_in_ready), 32'd0);
            chk("bp_data", 32'(e_data), 32'h5A);
        end
        in_valid = 1'b0; in_start = 1'b0; in_bit = 1'b0;
        chk("bp_ok", 32'(e_ok), 32'd1);
        out_ready = 1'b1;
        idle_cycle();
        chk("bp_release_valid", 32'(e_out_valid), 32'd0);
        chk("bp_release_ready", 32'(e_in_ready), 32'd1);

        // restart and drop: stray bits in IDLE, abort after 4 bits, then 0xFF
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b1);
        chk("drop_valid", 32'(e_out_valid), 32'd0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(i == 0, 1'b1);
        chk("restart_no_early", 32'(e_out_valid), 32'd0);
        send_bit(1'b0, 1'b0);
        chk("restart_valid", 32'(e_out_valid), 32'd1);
        chk("restart_data", 32'(e_data), 32'hFF);
        chk("restart_ok", 32'(e_ok), 32'd1);
        chk("restart_err", 32'(e_err), 32'd1);
        idle_cycle();
        chk("restart_single", 32'(e_out_valid), 32'd0);

        // saturation and clear
        err_clear = 1'b1;
        idle_cycle();
        err_clear = 1'b0;
        chk("clear_err", 32'(e_err), 32'd0);
        chk("clear_sat_err", 32'(s_err), 32'd0);
        for (int f = 1; f <= 5; f++) begin
            send_frame(8'h00, 1'b1, 0);
            chk("sat_ok", 32'(e_ok), 32'd0);
            chk("sat_err_even", 32'(e_err), 32'(f));
            chk("sat_err_small", 32'(s_err), (f > 3) ? 32'd3 : 32'(f));
            chk("sat_odd_err", 32'(o_err), 32'd0);
            idle_cycle();
        end
        for (int i = 0; i < 8; i++) send_bit(i == 0, 1'b0);
        err_clear = 1'b1;
        send_bit(1'b0, 1'b1);
        err_clear = 1'b0;
        chk("clear_prio_ok", 32'(e_ok), 32'd0);
        chk("clear_prio_err", 32'(e_err), 32'd0);
        chk("clear_prio_sat", 32'(s_err), 32'd0);
        idle_cycle();

        // reset mid-frame: first leave err=1 and out_data=0x5A behind
        send_frame(8'h5A, 1'b1, 0);
        chk("pre_rst_err", 32'(e_err), 32'd1);
        idle_cycle();
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b1);
        rst_n = 1'b0;
        #2;
        chk("midrst_ready", 32'(e_in_ready), 32'd1);
        chk("midrst_valid", 32'(e_out_valid), 32'd0);
        chk("midrst_data", 32'(e_data), 32'h0);
        chk("midrst_err", 32'(e_err), 32'd0);
        rst_n = 1'b1;
        idle_cycle();

        // reset during HOLD
        out_ready = 1'b0;
        send_frame(8'hA5, 1'b0, 0);
        chk("hold_pre_valid", 32'(e_out_valid), 32'd1);
        rst_n = 1'b0;
        #2;
        chk("holdrst_valid", 32'(e_out_valid), 32'd0);
        chk("holdrst_ready", 32'(e_in_ready), 32'd1);
        chk("holdrst_data", 32'(e_data), 32'h0);
        chk("holdrst_ok", 32'(e_ok), 32'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        idle_cycle();

        // frame 0x01 with parity 1 after reset
        send_frame(8'h01, 1'b1, 0);
        chk("post_valid", 32'(e_out_valid), 32'd1);
        chk("post_data", 32'(e_data), 32'h01);
        chk("post_ok", 32'(e_ok), 32'd1);
        chk("post_err", 32'(e_err), 32'd0);
        idle_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
